// File: rtl/opb_master_pkg.sv
// Shared constants for the OPB master: widths, FSM encoding,
// retry counter sizing and the user<->OPB bit-order constants.
package opb_master_pkg;

    localparam int OPB_AW  = 32;
    localparam int OPB_DW  = 32;
    localparam int OPB_BEW = OPB_DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int RETRY_W = 4;

    // User vectors are [N-1:0], OPB vectors are [0:N-1]; a positional
    // assignment lands user bit N-1 on OPB bit 0.
    localparam int ADDR_OPB_BIT0 = OPB_AW - 1;
    localparam int DATA_OPB_BIT0 = OPB_DW - 1;
    localparam int BE_OPB_BIT0   = OPB_BEW - 1;

endpackage

// File: rtl/opb_master_simulink_if.sv
// OPB master/arbiter/slave signal bundle, big-endian bit numbering
// as on the OPB itself.
interface opb_master_simulink_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            M_request;
    logic            M_busLock;
    logic            M_select;
    logic            M_RNW;
    logic [0:DW/8-1] M_BE;
    logic            M_seqAddr;
    logic [0:AW-1]   M_ABus;
    logic [0:DW-1]   M_DBus;
    logic            OPB_MGrant;
    logic            OPB_xferAck;
    logic            OPB_errAck;
    logic            OPB_retry;
    logic            OPB_timeout;
    logic [0:DW-1]   OPB_DBus;

    modport master (
        output M_request, M_busLock, M_select, M_RNW,
        output M_BE, M_seqAddr, M_ABus, M_DBus,
        input  OPB_MGrant, OPB_xferAck, OPB_errAck,
        input  OPB_retry, OPB_timeout, OPB_DBus
    );

    modport slave (
        input  M_request, M_busLock, M_select, M_RNW,
        input  M_BE, M_seqAddr, M_ABus, M_DBus,
        output OPB_MGrant, OPB_xferAck, OPB_errAck,
        output OPB_retry, OPB_timeout, OPB_DBus
    );
endinterface

// File: rtl/opb_master_simulink.sv
// Single-beat OPB master: latches one user command, arbitrates,
// transfers with bounded retries, and reports a one-cycle completion.
module opb_master_simulink
    import opb_master_pkg::*;
#(
    parameter int    C_OPB_AWIDTH = OPB_AW,
    parameter int    C_OPB_DWIDTH = OPB_DW,
    parameter string C_FAMILY     = "virtex5",
    parameter int    C_MAX_RETRY  = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    opb_master_simulink_if.master     bus,
    input  logic                      user_req,
    input  logic                      user_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   user_addr,
    input  logic [C_OPB_DWIDTH-1:0]   user_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0] user_be,
    output logic                      user_ready,
    output logic                      user_done,
    output logic                      user_err,
    output logic [C_OPB_DWIDTH-1:0]   user_rdata
);

    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(C_MAX_RETRY);

    logic [1:0]                state;
    logic [RETRY_W-1:0]        retry_cnt;
    logic                      cmd_rnw;
    logic [C_OPB_AWIDTH-1:0]   cmd_addr;
    logic [C_OPB_DWIDTH-1:0]   cmd_wdata;
    logic [C_OPB_DWIDTH/8-1:0] cmd_be;
    logic                      err_q;
    logic [C_OPB_DWIDTH-1:0]   rdata_q;
    logic                      sel;

    // Command latch, arbitration, transfer outcome and retry accounting.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state     <= ST_IDLE;
            retry_cnt <= '0;
            cmd_rnw   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_be    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    retry_cnt <= '0;
                    if (user_req) begin
                        cmd_rnw   <= user_rnw;
                        cmd_addr  <= user_addr;
                        cmd_wdata <= user_wdata;
                        cmd_be    <= user_be;
                        err_q     <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.OPB_MGrant)
                        state <= ST_XFER;
                end
                ST_XFER: begin
                    if (bus.OPB_xferAck) begin
                        // An errored read leaves the previous read data visible.
                        if (cmd_rnw && !bus.OPB_errAck)
                            rdata_q <= bus.OPB_DBus;
                        err_q <= bus.OPB_errAck;
                        state <= ST_DONE;
                    end else if (bus.OPB_timeout) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else if (bus.OPB_retry) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        if (retry_cnt + 1'b1 == RETRY_LIM) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are pure decodes of state, so reset clears them at once
    // and every value drops to zero whenever the bus is not selected.
    always_comb begin
        sel           = (state == ST_XFER);
        bus.M_request = (state == ST_REQ);
        bus.M_busLock = 1'b0;
        bus.M_seqAddr = 1'b0;
        bus.M_select  = sel;
        bus.M_RNW     = sel & cmd_rnw;
        bus.M_BE      = sel ? cmd_be : '0;
        bus.M_ABus    = sel ? cmd_addr : '0;
        bus.M_DBus    = (sel && !cmd_rnw) ? cmd_wdata : '0;
        user_ready    = (state == ST_IDLE);
        user_done     = (state == ST_DONE);
        user_err      = (state == ST_DONE) & err_q;
        user_rdata    = rdata_q;
    end

endmodule

// File: tb/tb_opb_master_simulink.sv
// Bench for opb_master_simulink: table-driven transactions against a
// configurable slave model, scoreboarded completions, reset sequences.
module tb_opb_master_simulink;

    localparam int MAXR = 4;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gd;
        int          ad;
        int          nr;
        logic        xack;
        logic        eack;
        logic        tout;
        logic        xretry;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          launch;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        user_req;
    logic        user_rnw;
    logic [31:0] user_addr;
    logic [31:0] user_wdata;
    logic [3:0]  user_be;
    logic        user_ready;
    logic        user_done;
    logic        user_err;
    logic [31:0] user_rdata;

    opb_master_simulink_if #(.AW(32), .DW(32)) bus ();

    opb_master_simulink #(
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_FAMILY("virtex5"),
        .C_MAX_RETRY(MAXR)
    ) dut (
        .OPB_Clk(clk),
        .OPB_Rst_n(rst_n),
        .bus(bus),
        .user_req(user_req),
        .user_rnw(user_rnw),
        .user_addr(user_addr),
        .user_wdata(user_wdata),
        .user_be(user_be),
        .user_ready(user_ready),
        .user_done(user_done),
        .user_err(user_err),
        .user_rdata(user_rdata)
    );

    int   checks;
    int   failures;
    int   cyc;
    int   done_cnt;
    int   windows;
    logic prev_done;
    exp_t sb[$];
    vec_t cfg;
    vec_t vt[10];
    logic [31:0] mdl_rdata;
    int   rq_cnt;
    int   sel_cnt;
    int   retries_left;
    logic sel_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Slave + arbiter model: responds to what the DUT shows at negedge.
    always @(negedge clk) begin
        bus.OPB_MGrant  = 1'b0;
        bus.OPB_xferAck = 1'b0;
        bus.OPB_errAck  = 1'b0;
        bus.OPB_retry   = 1'b0;
        bus.OPB_timeout = 1'b0;
        bus.OPB_DBus    = '0;
        if (rst_n && bus.M_request) begin
            rq_cnt++;
            if (rq_cnt > cfg.gd) bus.OPB_MGrant = 1'b1;
        end else begin
            rq_cnt = 0;
        end
        if (rst_n && bus.M_select) begin
            if (!sel_prev) begin
                windows++;
                check("abus", bus.M_ABus, cfg.addr);
                check("abus_bit0", 32'(bus.M_ABus[0]), 32'(cfg.addr[31]));
                check("be", 32'(bus.M_BE), 32'(cfg.be));
                check("rnw", 32'(bus.M_RNW), 32'(cfg.rnw));
                check("dbus", bus.M_DBus, cfg.rnw ? 32'h0 : cfg.wdata);
                check("req_in_xfer", 32'(bus.M_request), 32'h0);
            end
            sel_cnt++;
            if (sel_cnt > cfg.ad) begin
                if (retries_left > 0) begin
                    bus.OPB_retry = 1'b1;
                    retries_left--;
                end else begin
                    bus.OPB_xferAck = cfg.xack;
                    bus.OPB_errAck  = cfg.xack & cfg.eack;
                    bus.OPB_timeout = cfg.tout;
                    bus.OPB_retry   = cfg.xretry;
                    if (cfg.xack) bus.OPB_DBus = cfg.rd;
                end
            end
        end else begin
            sel_cnt = 0;
        end
        sel_prev = bus.M_select;
    end

    // OR-bus rule every cycle, plus completion scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!bus.M_select) begin
            checks++;
            if (bus.M_ABus !== '0 || bus.M_BE !== '0 ||
                bus.M_DBus !== '0 || bus.M_RNW !== 1'b0) begin
                failures++;
                $display("FAIL orbus: cyc %0d abus %08h be %h dbus %08h rnw %b expected 0",
                         cyc, bus.M_ABus, bus.M_BE, bus.M_DBus, bus.M_RNW);
            end
        end
        if (bus.M_busLock !== 1'b0 || bus.M_seqAddr !== 1'b0)
            check("tied0", {30'h0, bus.M_busLock, bus.M_seqAddr}, 32'h0);
        if (user_done === 1'b1) begin
            done_cnt++;
            check("done_width", 32'(prev_done), 32'h0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = sb.pop_front();
                check("err", 32'(user_err), 32'(e.err));
                check("rdata", user_rdata, e.rdata);
                check("latency", 32'(cyc - e.launch), 32'(e.lat));
            end
        end
        prev_done = user_done;
    end

    task automatic drive_cmd(input vec_t v);
        int k;
        k = 0;
        while (!user_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        user_req   = 1'b1;
        user_rnw   = v.rnw;
        user_addr  = v.addr;
        user_wdata = v.wdata;
        user_be    = v.be;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   w;
        int   start;
        int   k;
        cfg          = v;
        retries_left = v.nr;
        windows      = 0;
        w            = (v.nr >= MAXR) ? MAXR : v.nr + 1;
        e.err        = (v.nr >= MAXR) ? 1'b1 :
                       v.xack ? v.eack : v.tout;
        if (!e.err && v.rnw && v.xack) mdl_rdata = v.rd;
        e.rdata      = mdl_rdata;
        e.lat        = 4 + v.gd + v.ad + (w - 1) * (2 + v.gd + v.ad);
        start        = done_cnt;
        drive_cmd(v);
        e.launch     = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 user_req = 1'b0;
        k = 0;
        while (done_cnt == start && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got no done expected done", name);
            sb.delete();
        end
        check({name, "_windows"}, 32'(windows), 32'(w));
    endtask

    function automatic vec_t mk(logic rnw, logic [31:0] a, logic [31:0] d,
                                logic [3:0] be, int gd, int ad, int nr,
                                logic xa, logic ea, logic to, logic xr,
                                logic [31:0] rd);
        vec_t v;
        v.rnw = rnw; v.addr = a; v.wdata = d; v.be = be;
        v.gd = gd; v.ad = ad; v.nr = nr;
        v.xack = xa; v.eack = ea; v.tout = to; v.xretry = xr; v.rd = rd;
        return v;
    endfunction

    initial begin
        vec_t v;
        checks = 0; failures = 0; cyc = 0; done_cnt = 0; windows = 0;
        prev_done = 1'b0; mdl_rdata = '0;
        rq_cnt = 0; sel_cnt = 0; retries_left = 0; sel_prev = 1'b0;
        user_req = 1'b0; user_rnw = 1'b0; user_addr = '0;
        user_wdata = '0; user_be = '0;
        cfg = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        vt[0] = mk(0, 32'h01094C00, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1, 0, 0, 0, 0);
        vt[1] = mk(1, 32'h01094C04, 32'h0, 4'hF, 0, 3, 0, 1, 0, 0, 0, 32'h12345678);
        vt[2] = mk(0, 32'h00001000, 32'hA5A5A5A5, 4'hC, 0, 0, 3, 1, 0, 0, 0, 0);
        vt[3] = mk(1, 32'h00002000, 32'h0, 4'hF, 0, 0, 4, 1, 0, 0, 0, 32'h55555555);
        vt[4] = mk(1, 32'h00003000, 32'h0, 4'hF, 0, 0, 0, 1, 1, 0, 0, 32'hAAAA5555);
        vt[5] = mk(1, 32'h00004000, 32'h0, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0);
        vt[6] = mk(1, 32'h00005000, 32'h0, 4'h3, 0, 0, 0, 1, 0, 1, 1, 32'h0BADF00D);
        vt[7] = mk(0, 32'h00006000, 32'h13572468, 4'hF, 0, 0, 0, 0, 0, 1, 1, 0);
        vt[8] = mk(0, 32'h80000001, 32'h00FF00FF, 4'h5, 2, 1, 0, 1, 0, 0, 0, 0);
        vt[9] = mk(1, 32'h7FFFFFFC, 32'h0, 4'h8, 1, 0, 1, 1, 0, 0, 0, 32'hCAFEF00D);

        rst_n = 1'b0;
        #12;
        check("rst_ready", 32'(user_ready), 32'h1);
        check("rst_req", 32'(bus.M_request), 32'h0);
        check("rst_sel", 32'(bus.M_select), 32'h0);
        check("rst_done", 32'(user_done), 32'h0);
        check("rst_err", 32'(user_err), 32'h0);
        check("rst_rdata", user_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_rst", 32'(user_ready), 32'h1);

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // A second strobe while busy must be dropped, not queued.
        begin
            exp_t e;
            int start;
            v = mk(0, 32'h00000010, 32'h11111111, 4'h3, 1, 0, 0, 1, 0, 0, 0, 0);
            cfg = v; retries_left = 0; windows = 0; start = done_cnt;
            drive_cmd(v);
            e.err = 1'b0; e.rdata = mdl_rdata; e.lat = 5; e.launch = cyc;
            sb.push_back(e);
            @(posedge clk);
            #1 user_addr = 32'h00000020; user_wdata = 32'h22222222;
            @(posedge clk);
            #1 user_req = 1'b0;
            repeat (20) @(posedge clk);
            check("busy_req_dones", 32'(done_cnt - start), 32'h1);
            check("busy_req_windows", 32'(windows), 32'h1);
        end

        // Reset while waiting for a grant abandons the transfer.
        begin
            int start;
            v = mk(1, 32'h00009000, 32'h0, 4'hF, 1000, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF);
            cfg = v; retries_left = 0; windows = 0; start = done_cnt;
            drive_cmd(v);
            @(posedge clk);
            #1 user_req = 1'b0;
            repeat (10) @(negedge clk);
            check("pre_rst_req", 32'(bus.M_request), 32'h1);
            #2 rst_n = 1'b0;
            #1;
            check("mid_rst_req", 32'(bus.M_request), 32'h0);
            check("mid_rst_sel", 32'(bus.M_select), 32'h0);
            check("mid_rst_abus", bus.M_ABus, 32'h0);
            check("mid_rst_done", 32'(user_done), 32'h0);
            check("mid_rst_rdata", user_rdata, 32'h0);
            mdl_rdata = '0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1 check("ready_after_mid_rst", 32'(user_ready), 32'h1);
            repeat (5) @(posedge clk);
            check("no_done_after_rst", 32'(done_cnt - start), 32'h0);
            check("idle_after_rst_req", 32'(bus.M_request), 32'h0);
        end

        run_vec(vt[0], "post_rst");
        run_vec(vt[1], "post_rst_rd");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
